// File: rtl/vga_stream_reader_pkg.sv
// Shared timing defaults, FSM state type, pixel struct and the word unpack helper
// for the VGA frame-buffer stream reader.
package vga_stream_reader_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // RGB mode expands 5-bit fields by zero-filling the low bits; gray mode
    // replicates the low byte onto all three channels and ignores the mask.
    function automatic rgb_t unpack_pixel(input logic [15:0] d,
                                          input logic        rgb,
                                          input logic [2:0]  mask);
        rgb_t p;
        if (rgb) begin
            p.r = mask[2] ? {d[14:10], 3'b000} : 8'h00;
            p.g = mask[1] ? {d[9:5],   3'b000} : 8'h00;
            p.b = mask[0] ? {d[4:0],   3'b000} : 8'h00;
        end else begin
            p.r = d[7:0];
            p.g = d[7:0];
            p.b = d[7:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/vga_stream_reader_if.sv
// Read port of the SDRAM frame-buffer FIFO: pop request, one-cycle-late data, empty flag.
interface vga_stream_reader_if;
    logic        fifo_rd_req;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;

    modport master (output fifo_rd_req, input fifo_rd_data, input fifo_empty);
    modport slave  (input fifo_rd_req, output fifo_rd_data, output fifo_empty);
endinterface

// File: rtl/vga_stream_reader_timing_gen.sv
// Horizontal/vertical position counters and the position-decoded flags derived
// from them. Counters are held at (0,0) whenever run_i is low.
module vga_timing_gen
    import vga_stream_reader_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic pixel_clk_i,
    input  logic reset_i,
    input  logic run_i,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic wrap_o,
    output logic load_pt_o,
    output logic origin_o
);

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last_s, v_last_s;

    assign h_last_s  = (h_cnt_q == H_LAST_C);
    assign v_last_s  = (v_cnt_q == V_LAST_C);
    assign wrap_o    = h_last_s && v_last_s;
    assign active_o  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hsync_o   = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
    assign vsync_o   = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
    assign load_pt_o = (v_cnt_q == V_ACT_C) && (h_cnt_q == '0);
    assign origin_o  = (v_cnt_q == '0) && (h_cnt_q == '0);

    // Next position: hold at origin when stopped, otherwise raster-scan with wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last_s) begin
            h_cnt_d = '0;
            if (v_last_s) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end
    end

    // Position counter registers
    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

endmodule

// File: rtl/vga_stream_reader.sv
// Frame-buffer consumer: pops pixel words from the SDRAM read FIFO in step with
// 640x480@60 VGA timing and drives sync, blanking and 8-bit RGB pins.
// Control outputs are registered one cycle behind the counters so they line up
// with FIFO data, which arrives one cycle after the pop.
module vga_stream_reader
    import vga_stream_reader_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_D,
    parameter int   H_FP     = H_FP_D,
    parameter int   H_SYNC   = H_SYNC_D,
    parameter int   H_BP     = H_BP_D,
    parameter int   V_ACTIVE = V_ACTIVE_D,
    parameter int   V_FP     = V_FP_D,
    parameter int   V_SYNC   = V_SYNC_D,
    parameter int   V_BP     = V_BP_D,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 pixel_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 rgb_mode_i,
    input  logic [2:0]           chan_mask_i,
    vga_stream_reader_if.master  fifo,
    output logic                 frame_load_o,
    output logic                 h_sync_o,
    output logic                 v_sync_o,
    output logic                 n_blank_o,
    output logic                 n_sync_o,
    output logic [7:0]           vga_r_o,
    output logic [7:0]           vga_g_o,
    output logic [7:0]           vga_b_o,
    output logic [15:0]          underflow_cnt_o
);

    state_e      state_q;
    logic        frame_load_q;
    logic        h_sync_q;
    logic        v_sync_q;
    logic        n_blank_q;
    logic        valid_q;
    logic        mode_q;
    logic [2:0]  mask_q;
    logic [15:0] underflow_q;

    logic run_s, active_s, hsync_s, vsync_s, wrap_s, load_pt_s, origin_s;
    logic stream_px_s, pop_s, miss_s;
    rgb_t pix_s;

    assign run_s = (state_q != IDLE);

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .pixel_clk_i (pixel_clk_i),
        .reset_i     (reset_i),
        .run_i       (run_s),
        .active_o    (active_s),
        .hsync_o     (hsync_s),
        .vsync_o     (vsync_s),
        .wrap_o      (wrap_s),
        .load_pt_o   (load_pt_s),
        .origin_o    (origin_s)
    );

    // An empty FIFO suppresses the pop so the FIFO is never over-read; the
    // pixel is counted as missed and shown black.
    assign stream_px_s      = (state_q == STREAM) && active_s;
    assign pop_s            = stream_px_s && !fifo.fifo_empty;
    assign miss_s           = stream_px_s && fifo.fifo_empty;
    assign fifo.fifo_rd_req = pop_s;

    // FSM, frame-latched mode, underflow counter and the registered output stage
    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            frame_load_q <= 1'b0;
            h_sync_q     <= ~SYNC_POL;
            v_sync_q     <= ~SYNC_POL;
            n_blank_q    <= 1'b0;
            valid_q      <= 1'b0;
            mode_q       <= 1'b0;
            mask_q       <= 3'b000;
            underflow_q  <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (wrap_s) begin
                        state_q <= enable_i ? STREAM : IDLE;
                    end
                end
                STREAM: begin
                    if (wrap_s && !enable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            frame_load_q <= run_s && load_pt_s;
            h_sync_q     <= (run_s && hsync_s) ? SYNC_POL : ~SYNC_POL;
            v_sync_q     <= (run_s && vsync_s) ? SYNC_POL : ~SYNC_POL;
            n_blank_q    <= run_s && active_s;
            valid_q      <= pop_s;

            if (origin_s) begin
                mode_q <= rgb_mode_i;
                mask_q <= chan_mask_i;
            end

            if (miss_s && (underflow_q != 16'hFFFF)) begin
                underflow_q <= underflow_q + 16'd1;
            end
        end
    end

    // Unpack the word the FIFO presents this cycle; black unless it was popped last cycle
    always_comb begin
        pix_s = unpack_pixel(fifo.fifo_rd_data, mode_q, mask_q);
        if (valid_q) begin
            vga_r_o = pix_s.r;
            vga_g_o = pix_s.g;
            vga_b_o = pix_s.b;
        end else begin
            vga_r_o = 8'h00;
            vga_g_o = 8'h00;
            vga_b_o = 8'h00;
        end
    end

    assign frame_load_o    = frame_load_q;
    assign h_sync_o        = h_sync_q;
    assign v_sync_o        = v_sync_q;
    assign n_blank_o       = n_blank_q;
    assign n_sync_o        = 1'b1;
    assign underflow_cnt_o = underflow_q;

endmodule

// File: tb/tb_vga_stream_reader.sv
// Directed bench for vga_stream_reader using a shrunken raster (15x10) so that
// whole frames fit in a short run. Expected values come from the raster
// geometry and hand-chosen words, not from the design.
module tb_vga_stream_reader;

    localparam int H_ACT = 8;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;   // 15
    localparam int V_ACT = 6;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 1;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;   // 10
    localparam int F_TOT = H_TOT * V_TOT;                // 150
    localparam int H_SS  = H_ACT + H_FP;                 // 10
    localparam int H_SE  = H_SS + H_SY;                  // 13
    localparam int V_SS  = V_ACT + V_FP;                 // 7
    localparam int V_SE  = V_SS + V_SY;                  // 9
    localparam int LOAD_I = V_ACT * H_TOT + 1;           // registered pulse cycle

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rgb_mode;
    logic [2:0]  chan_mask;
    logic        frame_load, h_sync, v_sync, n_blank, n_sync;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [15:0] underflow_cnt;
    logic [15:0] src_word;

    int errors = 0;
    int checks = 0;

    vga_stream_reader_if bus ();

    vga_stream_reader #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .SYNC_POL (1'b0)
    ) dut (
        .pixel_clk_i     (clk),
        .reset_i         (reset),
        .enable_i        (enable),
        .rgb_mode_i      (rgb_mode),
        .chan_mask_i     (chan_mask),
        .fifo            (bus),
        .frame_load_o    (frame_load),
        .h_sync_o        (h_sync),
        .v_sync_o        (v_sync),
        .n_blank_o       (n_blank),
        .n_sync_o        (n_sync),
        .vga_r_o         (vga_r),
        .vga_g_o         (vga_g),
        .vga_b_o         (vga_b),
        .underflow_cnt_o (underflow_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: a pop presents the source word on the next cycle
    always @(posedge clk) begin
        if (reset) bus.fifo_rd_data <= 16'h0000;
        else if (bus.fifo_rd_req) bus.fifo_rd_data <= src_word;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rd_req"},     32'(bus.fifo_rd_req), 32'd0);
        chk({tag, ".frame_load"}, 32'(frame_load),      32'd0);
        chk({tag, ".h_sync"},     32'(h_sync),          32'd1);
        chk({tag, ".v_sync"},     32'(v_sync),          32'd1);
        chk({tag, ".n_blank"},    32'(n_blank),         32'd0);
        chk({tag, ".n_sync"},     32'(n_sync),          32'd1);
        chk({tag, ".rgb"},        {8'h00, vga_r, vga_g, vga_b}, 32'd0);
        chk({tag, ".underflow"},  32'(underflow_cnt),   32'd0);
    endtask

    // One full frame starting at counter (0,0); compares every cycle and reports per signal
    task automatic run_frame(input string tag, input bit run, input bit stream,
                             input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                             input logic mid_rgb, input logic [2:0] mid_mask,
                             input int e_p0, input int e_len, input logic [15:0] nxt_word,
                             input bit drop_en, input int exp_pops, input logic [15:0] exp_uf);
        int  h, v, ph, pv, ap;
        bit  act, pact, phs, pvs, emp, req_e, preq_e;
        int  bad_req, bad_load, bad_hs, bad_vs, bad_blank, bad_pix, pops, hs_low, vs_low;
        logic [23:0] pix_e;
        bad_req = 0; bad_load = 0; bad_hs = 0; bad_vs = 0; bad_blank = 0; bad_pix = 0;
        pops = 0; hs_low = 0; vs_low = 0; preq_e = 1'b0;
        for (int i = 0; i < F_TOT; i++) begin
            h   = i % H_TOT;
            v   = i / H_TOT;
            act = (h < H_ACT) && (v < V_ACT);
            ap  = v * H_ACT + h;
            emp = stream && act && (ap >= e_p0) && (ap < e_p0 + e_len);
            @(posedge clk); #1;
            bus.fifo_empty = emp;
            if (i == 60) begin rgb_mode = mid_rgb; chan_mask = mid_mask; end
            if (i == 45 && drop_en) enable = 1'b0;
            if (i == 140) src_word = nxt_word;
            req_e = run && stream && act && !emp;
            ph  = (i > 0) ? (i - 1) % H_TOT : 0;
            pv  = (i > 0) ? (i - 1) / H_TOT : 0;
            pact = run && (i > 0) && (ph < H_ACT) && (pv < V_ACT);
            phs  = run && (i > 0) && (ph >= H_SS) && (ph < H_SE);
            pvs  = run && (i > 0) && (pv >= V_SS) && (pv < V_SE);
            pix_e = preq_e ? {er, eg, eb} : 24'h000000;
            @(negedge clk);
            if (bus.fifo_rd_req !== req_e) bad_req++;
            if (frame_load !== (run && (i == LOAD_I))) bad_load++;
            if (h_sync !== !phs) bad_hs++;
            if (v_sync !== !pvs) bad_vs++;
            if (n_blank !== pact) bad_blank++;
            if ({vga_r, vga_g, vga_b} !== pix_e) bad_pix++;
            if (bus.fifo_rd_req === 1'b1) pops++;
            if (h_sync === 1'b0) hs_low++;
            if (v_sync === 1'b0) vs_low++;
            preq_e = req_e;
        end
        chk({tag, ".req_pattern"},  32'(bad_req),   32'd0);
        chk({tag, ".frame_load"},   32'(bad_load),  32'd0);
        chk({tag, ".h_sync"},       32'(bad_hs),    32'd0);
        chk({tag, ".v_sync"},       32'(bad_vs),    32'd0);
        chk({tag, ".n_blank"},      32'(bad_blank), 32'd0);
        chk({tag, ".pixels"},       32'(bad_pix),   32'd0);
        chk({tag, ".pops"},         32'(pops),      32'(exp_pops));
        chk({tag, ".hsync_cycles"}, 32'(hs_low),    run ? 32'(H_SY * V_TOT) : 32'd0);
        chk({tag, ".vsync_cycles"}, 32'(vs_low),    run ? 32'(V_SY * H_TOT) : 32'd0);
        chk({tag, ".underflow"},    32'(underflow_cnt), 32'(exp_uf));
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        rgb_mode       = 1'b1;
        chan_mask      = 3'b111;
        bus.fifo_empty = 1'b0;
        src_word       = 16'h7FFF;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");

        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("idle.rd_req", 32'(bus.fifo_rd_req), 32'd0);

        // Arming frame: timing and frame_load run, no pops
        run_frame("arm", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111, 0, 0,
                  16'h7FFF, 1'b0, 0, 16'h0000);
        // RGB full mask; mask changed mid-frame must not take effect yet
        run_frame("rgb_full", 1'b1, 1'b1, 8'hF8, 8'hF8, 8'hF8, 1'b1, 3'b010, 0, 0,
                  16'h03E0, 1'b0, H_ACT * V_ACT, 16'h0000);
        // Green-only mask; rgb_mode toggled mid-frame must not take effect yet
        run_frame("rgb_green", 1'b1, 1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 3'b010, 0, 0,
                  16'hAB5A, 1'b0, H_ACT * V_ACT, 16'h0000);
        // Gray mode with 10 consecutive empty active pixels
        run_frame("gray_underflow", 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0, 3'b010, 20, 10,
                  16'hAB5A, 1'b0, H_ACT * V_ACT - 10, 16'd10);
        // enable dropped on line 3: this frame still completes
        run_frame("enable_drop", 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0, 3'b010, 0, 0,
                  16'hAB5A, 1'b1, H_ACT * V_ACT, 16'd10);
        // Back in IDLE: counters stopped, nothing popped or pulsed
        run_frame("idle", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'b010, 0, 0,
                  16'hAB5A, 1'b0, 0, 16'd10);

        // Re-arm, then reset in the middle of a streaming frame
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("rearm.rd_req", 32'(bus.fifo_rd_req), 32'd0);
        run_frame("arm2", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'b010, 0, 0,
                  16'hAB5A, 1'b0, 0, 16'd10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midframe.rd_req",  32'(bus.fifo_rd_req), 32'd1);
        chk("midframe.n_blank", 32'(n_blank),         32'd1);
        chk("midframe.vga_r",   32'(vga_r),           32'h5A);
        chk("midframe.uf",      32'(underflow_cnt),   32'd10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
